// File: rtl/fsmc_pingpong_bufer_pkg.sv
// Shared sizing and types for the FSMC ping-pong frame buffer.
// Widths mirror the project-wide FSMC header values.
package fsmc_pingpong_bufer_pkg;

    localparam int FSMC_WIDTH     = 16;
    localparam int DATA_READ_RAZR = 5;
    localparam int LENTH_BUFER    = 15;

    localparam int DEPTH = LENTH_BUFER + 1;
    localparam int AW    = DATA_READ_RAZR;
    localparam int IDXW  = $clog2(DEPTH);

    typedef logic [FSMC_WIDTH-1:0] word_t;
    typedef logic [AW-1:0]         cnt_t;
    typedef logic [IDXW-1:0]       idx_t;
    typedef logic [IDXW:0]         ram_addr_t;

    localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

    function automatic cnt_t cnt_max(cnt_t a, cnt_t b);
        return (a > b) ? a : b;
    endfunction

    // Bank index forms the top address bit of the shared RAM.
    function automatic ram_addr_t ram_addr(logic bank, idx_t idx);
        return {bank, idx};
    endfunction

endpackage

// File: rtl/fsmc_pingpong_bufer_if.sv
// Generator/host side bus of the ping-pong buffer.
// The master modport is the driving side (generator plus FSMC host), slave is the buffer.
interface fsmc_pingpong_bufer_if;
    import fsmc_pingpong_bufer_pkg::*;

    logic  BUFER_EN;
    word_t DATA_IN;
    cnt_t  BYTE_CNT;
    logic  BUFER_CHANGE;
    logic  RD_REQ;
    cnt_t  RD_ADDR;
    logic  READ_DONE;
    logic  OVR_CLR;

    word_t RD_DATA;
    logic  RD_VALID;
    logic  DATA_READY;
    cnt_t  WORD_CNT;
    logic  RD_BANK;
    logic  OVERRUN;

    modport master (
        output BUFER_EN, DATA_IN, BYTE_CNT, BUFER_CHANGE,
        output RD_REQ, RD_ADDR, READ_DONE, OVR_CLR,
        input  RD_DATA, RD_VALID, DATA_READY, WORD_CNT, RD_BANK, OVERRUN
    );

    modport slave (
        input  BUFER_EN, DATA_IN, BYTE_CNT, BUFER_CHANGE,
        input  RD_REQ, RD_ADDR, READ_DONE, OVR_CLR,
        output RD_DATA, RD_VALID, DATA_READY, WORD_CNT, RD_BANK, OVERRUN
    );

endinterface

// File: rtl/fsmc_pingpong_bufer_pp_dpram.sv
// Simple dual-port RAM holding both banks, addressed as {bank, index}.
// One write port, one registered read port; written to infer block RAM.
module pp_dpram
    import fsmc_pingpong_bufer_pkg::*;
(
    input  logic      CLK,
    input  logic      we,
    input  ram_addr_t waddr,
    input  word_t     wdata,
    input  logic      re,
    input  ram_addr_t raddr,
    output word_t     rdata
);

    word_t mem [2**(IDXW+1)];

    // NOTE: the array and its read register have no reset; a reset would block RAM inference.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fsmc_pingpong_bufer.sv
// Ping-pong frame buffer between the data generator and the FSMC host.
// Holds bank selection, end-of-frame toggle detect, frame flags and address range checks.
module fsmc_pingpong_bufer
    import fsmc_pingpong_bufer_pkg::*;
(
    input  logic                        CLK,
    input  logic                        RESET,
    fsmc_pingpong_bufer_if.slave        bus
);

    logic      wr_bank;
    logic      chg_d;
    cnt_t      wr_max;
    cnt_t      wr_max_nxt;
    logic      swap;
    logic      wr_ok;
    logic      rd_ok;
    logic      rd_zero_q;
    word_t     ram_q;
    ram_addr_t ram_waddr;
    ram_addr_t ram_raddr;

    always_comb begin
        // NOTE: every variable gets a value before any branch, so no latch can be inferred.
        wr_max_nxt = wr_max;
        wr_ok      = bus.BUFER_EN && (bus.BYTE_CNT < DEPTH_CNT);
        rd_ok      = bus.RD_REQ && (bus.RD_ADDR < DEPTH_CNT);
        swap       = (bus.BUFER_CHANGE != chg_d);
        if (wr_ok) begin
            wr_max_nxt = cnt_max(wr_max, bus.BYTE_CNT + cnt_t'(1));
        end
    end

    assign ram_waddr = ram_addr(wr_bank, bus.BYTE_CNT[IDXW-1:0]);
    assign ram_raddr = ram_addr(bus.RD_BANK, bus.RD_ADDR[IDXW-1:0]);

    pp_dpram u_ram (
        .CLK   (CLK),
        .we    (wr_ok),
        .waddr (ram_waddr),
        .wdata (bus.DATA_IN),
        .re    (rd_ok),
        .raddr (ram_raddr),
        .rdata (ram_q)
    );

    // NOTE: state registers use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_bank        <= 1'b0;
            chg_d          <= 1'b0;
            wr_max         <= '0;
            rd_zero_q      <= 1'b1;
            bus.RD_VALID   <= 1'b0;
            bus.DATA_READY <= 1'b0;
            bus.WORD_CNT   <= '0;
            bus.RD_BANK    <= 1'b1;
            bus.OVERRUN    <= 1'b0;
        end else begin
            chg_d        <= bus.BUFER_CHANGE;
            bus.RD_VALID <= bus.RD_REQ;

            // Out-of-range reads return zero without touching the RAM read register.
            if (bus.RD_REQ) begin
                rd_zero_q <= !rd_ok;
            end

            if (swap) begin
                bus.RD_BANK    <= wr_bank;
                wr_bank        <= ~wr_bank;
                bus.WORD_CNT   <= wr_max_nxt;
                wr_max         <= '0;
                bus.DATA_READY <= 1'b1;
            end else begin
                wr_max <= wr_max_nxt;
                if (bus.READ_DONE) begin
                    bus.DATA_READY <= 1'b0;
                end
            end

            // A frame lost while unacknowledged beats a simultaneous clear.
            if (swap && bus.DATA_READY && !bus.READ_DONE) begin
                bus.OVERRUN <= 1'b1;
            end else if (bus.OVR_CLR) begin
                bus.OVERRUN <= 1'b0;
            end
        end
    end

    assign bus.RD_DATA = rd_zero_q ? '0 : ram_q;

endmodule

// File: tb/tb_fsmc_pingpong_bufer.sv
// Directed self-checking bench for the ping-pong frame buffer.
module tb_fsmc_pingpong_bufer;
    import fsmc_pingpong_bufer_pkg::*;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    fsmc_pingpong_bufer_if bus ();

    fsmc_pingpong_bufer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic write_word(input cnt_t a, input word_t d);
        bus.BUFER_EN = 1'b1;
        bus.BYTE_CNT = a;
        bus.DATA_IN  = d;
        tick();
        bus.BUFER_EN = 1'b0;
    endtask

    task automatic toggle();
        bus.BUFER_CHANGE = ~bus.BUFER_CHANGE;
        tick();
    endtask

    task automatic read_word(input cnt_t a, output word_t d, output logic v);
        bus.RD_REQ  = 1'b1;
        bus.RD_ADDR = a;
        tick();
        bus.RD_REQ = 1'b0;
        d = bus.RD_DATA;
        v = bus.RD_VALID;
    endtask

    task automatic test_reset();
        RESET            = 1'b1;
        bus.BUFER_EN     = 1'b0;
        bus.DATA_IN      = '0;
        bus.BYTE_CNT     = '0;
        bus.BUFER_CHANGE = 1'b0;
        bus.RD_REQ       = 1'b0;
        bus.RD_ADDR      = '0;
        bus.READ_DONE    = 1'b0;
        bus.OVR_CLR      = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        checks++;
        if (bus.DATA_READY !== 1'b0 || bus.OVERRUN !== 1'b0 || bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got ready=%0b ovr=%0b valid=%0b want 0 0 0",
                     bus.DATA_READY, bus.OVERRUN, bus.RD_VALID);
        end
        checks++;
        if (bus.WORD_CNT !== cnt_t'(0) || bus.RD_BANK !== 1'b1 || bus.RD_DATA !== word_t'(0)) begin
            errors++;
            $display("FAIL reset_values got cnt=%0d bank=%0b data=%h want 0 1 0",
                     bus.WORD_CNT, bus.RD_BANK, bus.RD_DATA);
        end
    endtask

    task automatic test_publish();
        word_t d;
        logic  v;
        for (int i = 0; i < 10; i++) write_word(cnt_t'(i), word_t'(16'h10 + i));
        checks++;
        if (bus.DATA_READY !== 1'b0) begin
            errors++;
            $display("FAIL t1_ready_before got %0b want 0", bus.DATA_READY);
        end
        toggle();
        checks++;
        if (bus.DATA_READY !== 1'b1 || bus.WORD_CNT !== cnt_t'(10) || bus.RD_BANK !== 1'b0) begin
            errors++;
            $display("FAIL t1_publish got ready=%0b cnt=%0d bank=%0b want 1 10 0",
                     bus.DATA_READY, bus.WORD_CNT, bus.RD_BANK);
        end
        read_word(cnt_t'(3), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h0013) begin
            errors++;
            $display("FAIL t1_read got valid=%0b data=%h want 1 0013", v, d);
        end
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b0 || bus.RD_DATA !== 16'h0013) begin
            errors++;
            $display("FAIL t1_read_hold got valid=%0b data=%h want 0 0013", bus.RD_VALID, bus.RD_DATA);
        end
    endtask

    task automatic test_pingpong();
        word_t d;
        logic  v;
        for (int i = 0; i < 6; i++) begin
            bus.BUFER_EN = 1'b1;
            bus.BYTE_CNT = cnt_t'(i);
            bus.DATA_IN  = word_t'(16'hAA + i);
            bus.RD_REQ   = 1'b1;
            bus.RD_ADDR  = cnt_t'(i);
            tick();
            checks++;
            if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== word_t'(16'h10 + i)) begin
                errors++;
                $display("FAIL t2_read_old[%0d] got valid=%0b data=%h want 1 %h",
                         i, bus.RD_VALID, bus.RD_DATA, word_t'(16'h10 + i));
            end
        end
        bus.BUFER_EN  = 1'b0;
        bus.RD_REQ    = 1'b0;
        bus.READ_DONE = 1'b1;
        tick();
        bus.READ_DONE = 1'b0;
        checks++;
        if (bus.DATA_READY !== 1'b0) begin
            errors++;
            $display("FAIL t2_done got ready=%0b want 0", bus.DATA_READY);
        end
        toggle();
        checks++;
        if (bus.RD_BANK !== 1'b1 || bus.WORD_CNT !== cnt_t'(6) || bus.DATA_READY !== 1'b1 ||
            bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t2_swap got bank=%0b cnt=%0d ready=%0b ovr=%0b want 1 6 1 0",
                     bus.RD_BANK, bus.WORD_CNT, bus.DATA_READY, bus.OVERRUN);
        end
        read_word(cnt_t'(2), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h00AC) begin
            errors++;
            $display("FAIL t2_read_new got valid=%0b data=%h want 1 00ac", v, d);
        end
    endtask

    task automatic test_overrun();
        write_word(cnt_t'(0), 16'h0055);
        toggle();
        checks++;
        if (bus.OVERRUN !== 1'b1 || bus.WORD_CNT !== cnt_t'(1) || bus.RD_BANK !== 1'b0) begin
            errors++;
            $display("FAIL t3_overrun got ovr=%0b cnt=%0d bank=%0b want 1 1 0",
                     bus.OVERRUN, bus.WORD_CNT, bus.RD_BANK);
        end
        bus.OVR_CLR = 1'b1;
        tick();
        bus.OVR_CLR = 1'b0;
        checks++;
        if (bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t3_clear got ovr=%0b want 0", bus.OVERRUN);
        end
        bus.OVR_CLR = 1'b1;
        toggle();
        checks++;
        if (bus.OVERRUN !== 1'b1 || bus.WORD_CNT !== cnt_t'(0) || bus.RD_BANK !== 1'b1) begin
            errors++;
            $display("FAIL t3_set_wins got ovr=%0b cnt=%0d bank=%0b want 1 0 1",
                     bus.OVERRUN, bus.WORD_CNT, bus.RD_BANK);
        end
        tick();
        bus.OVR_CLR = 1'b0;
        checks++;
        if (bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t3_clear2 got ovr=%0b want 0", bus.OVERRUN);
        end
    endtask

    task automatic test_done_with_swap();
        word_t d;
        logic  v;
        bus.BUFER_EN  = 1'b1;
        bus.BYTE_CNT  = cnt_t'(4);
        bus.DATA_IN   = 16'h0077;
        bus.READ_DONE = 1'b1;
        toggle();
        bus.BUFER_EN  = 1'b0;
        bus.READ_DONE = 1'b0;
        checks++;
        if (bus.DATA_READY !== 1'b1 || bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t4_swap_wins got ready=%0b ovr=%0b want 1 0", bus.DATA_READY, bus.OVERRUN);
        end
        checks++;
        if (bus.WORD_CNT !== cnt_t'(5) || bus.RD_BANK !== 1'b0) begin
            errors++;
            $display("FAIL t4_swap_write got cnt=%0d bank=%0b want 5 0", bus.WORD_CNT, bus.RD_BANK);
        end
        read_word(cnt_t'(4), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h0077) begin
            errors++;
            $display("FAIL t4_read got valid=%0b data=%h want 1 0077", v, d);
        end
        bus.READ_DONE = 1'b1;
        tick();
        tick();
        bus.READ_DONE = 1'b0;
        checks++;
        if (bus.DATA_READY !== 1'b0 || bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t4_done_idle got ready=%0b ovr=%0b want 0 0", bus.DATA_READY, bus.OVERRUN);
        end
    endtask

    task automatic test_range();
        word_t d;
        logic  v;
        write_word(DEPTH_CNT, 16'h00EE);
        write_word(cnt_t'(2), 16'h0033);
        toggle();
        checks++;
        if (bus.WORD_CNT !== cnt_t'(3) || bus.RD_BANK !== 1'b1 || bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t5_count got cnt=%0d bank=%0b ovr=%0b want 3 1 0",
                     bus.WORD_CNT, bus.RD_BANK, bus.OVERRUN);
        end
        read_word(DEPTH_CNT, d, v);
        checks++;
        if (v !== 1'b1 || d !== word_t'(0)) begin
            errors++;
            $display("FAIL t5_oob_read got valid=%0b data=%h want 1 0000", v, d);
        end
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b0 || bus.RD_DATA !== word_t'(0)) begin
            errors++;
            $display("FAIL t5_oob_hold got valid=%0b data=%h want 0 0000", bus.RD_VALID, bus.RD_DATA);
        end
        read_word(cnt_t'(0), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h00AA) begin
            errors++;
            $display("FAIL t5_no_alias got valid=%0b data=%h want 1 00aa", v, d);
        end
    endtask

    task automatic test_back_to_back();
        cnt_t  addrs [3] = '{cnt_t'(0), cnt_t'(1), cnt_t'(2)};
        word_t exp   [3] = '{16'h00AA, 16'h00AB, 16'h0033};
        bus.RD_REQ = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.RD_ADDR = addrs[i];
            tick();
            checks++;
            if (bus.RD_VALID !== 1'b1 || bus.RD_DATA !== exp[i]) begin
                errors++;
                $display("FAIL b2b[%0d] got valid=%0b data=%h want 1 %h",
                         i, bus.RD_VALID, bus.RD_DATA, exp[i]);
            end
        end
        bus.RD_REQ = 1'b0;
        tick();
        checks++;
        if (bus.RD_VALID !== 1'b0) begin
            errors++;
            $display("FAIL b2b_end got valid=%0b want 0", bus.RD_VALID);
        end
    endtask

    task automatic test_reset_mid_frame();
        word_t d;
        logic  v;
        for (int i = 0; i < 5; i++) write_word(cnt_t'(i), word_t'(16'h60 + i));
        RESET = 1'b1;
        #1;
        checks++;
        if (bus.DATA_READY !== 1'b0 || bus.WORD_CNT !== cnt_t'(0) || bus.RD_BANK !== 1'b1 ||
            bus.OVERRUN !== 1'b0 || bus.RD_VALID !== 1'b0 || bus.RD_DATA !== word_t'(0)) begin
            errors++;
            $display("FAIL t6_async got ready=%0b cnt=%0d bank=%0b ovr=%0b valid=%0b data=%h want 0 0 1 0 0 0000",
                     bus.DATA_READY, bus.WORD_CNT, bus.RD_BANK, bus.OVERRUN, bus.RD_VALID, bus.RD_DATA);
        end
        bus.BUFER_CHANGE = 1'b0;
        tick();
        tick();
        RESET = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) write_word(cnt_t'(i), word_t'(16'hC0 + i));
        toggle();
        checks++;
        if (bus.WORD_CNT !== cnt_t'(3) || bus.RD_BANK !== 1'b0 || bus.DATA_READY !== 1'b1 ||
            bus.OVERRUN !== 1'b0) begin
            errors++;
            $display("FAIL t6_refill got cnt=%0d bank=%0b ready=%0b ovr=%0b want 3 0 1 0",
                     bus.WORD_CNT, bus.RD_BANK, bus.DATA_READY, bus.OVERRUN);
        end
        read_word(cnt_t'(1), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h00C1) begin
            errors++;
            $display("FAIL t6_read_new got valid=%0b data=%h want 1 00c1", v, d);
        end
        read_word(cnt_t'(3), d, v);
        checks++;
        if (v !== 1'b1 || d !== 16'h0063) begin
            errors++;
            $display("FAIL t6_read_kept got valid=%0b data=%h want 1 0063", v, d);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_publish();
        test_pingpong();
        test_overrun();
        test_done_with_swap();
        test_range();
        test_back_to_back();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
